// File: rtl/datapath_core_gen.sv
// Parametrised CPU datapath: register file, ALU, status flags, PC, IR and bus muxes,
// with a req/ack external memory port that stalls the core and times out into a sticky bus error.
module datapath_core_gen #(
  parameter int             DW       = 64,
  parameter int             AW       = 32,
  parameter int             IW       = 32,
  parameter int             NREG     = 32,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int             TIMEOUT  = 16,
  localparam int            RW_      = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           AS,
  input  logic [1:0]     DS,
  input  logic [1:0]     PS,
  input  logic           PC_Sel,
  input  logic           K_Sel,
  input  logic           IL,
  input  logic           SL,
  input  logic           RW,
  input  logic           MW,
  input  logic [3:0]     FS,
  input  logic           C0,
  input  logic [RW_-1:0] DA,
  input  logic [RW_-1:0] SA,
  input  logic [RW_-1:0] SB,
  input  logic [DW-1:0]  K,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_req,
  output logic           mem_we,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  output logic           stall,
  output logic           bus_err,
  output logic [3:0]     SF,
  output logic [AW-1:0]  PC_Out,
  output logic [IW-1:0]  IR_Out
);

  localparam int             SHW = $clog2(DW);
  localparam int             CW  = $clog2(TIMEOUT + 1);
  localparam logic [RW_-1:0] XZR = RW_'(NREG - 1);

  logic        [DW-1:0] rf [NREG];
  logic        [AW-1:0] pc_q;
  logic        [IW-1:0] ir_q;
  logic        [3:0]    sf_q;
  logic                 bus_err_q;
  logic                 abort_q;
  logic        [CW-1:0] cnt_q;

  logic signed [DW-1:0] a, b, bop, op2, f, d;
  logic        [DW:0]   sum;
  logic                 cin, carry, ovf, access;
  logic        [AW-1:0] pc_in, pc_nxt;
  logic        [3:0]    status;

  // Signed overflow of a two's-complement add: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Operand fetch: the XZR slot is never written, but the read is forced to zero regardless.
  assign a   = (SA == XZR) ? '0 : rf[SA];
  assign b   = (SB == XZR) ? '0 : rf[SB];
  assign bop = K_Sel ? K : b;

  always_comb begin
    op2   = (FS == 4'b0101) ? ~bop : bop;
    cin   = (FS == 4'b0101) ? 1'b1 : C0;
    sum   = {1'b0, a} + {1'b0, op2} + {{DW{1'b0}}, cin};
    f     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (FS)
      4'b0000: f = a & bop;
      4'b0001: f = a | bop;
      4'b0010: f = a ^ bop;
      4'b0011: f = ~a;
      4'b0100, 4'b0101: begin
        f     = sum[DW-1:0];
        carry = sum[DW];
        ovf   = add_ovf(a[DW-1], op2[DW-1], sum[DW-1]);
      end
      4'b0110: f = a << bop[SHW-1:0];
      4'b0111: f = a >> bop[SHW-1:0];
      4'b1000: f = bop;
      4'b1001: f = a;
      default: f = '0;
    endcase
    status = {ovf, carry, f[DW-1], (f == '0)};
  end

  // An aborted load returns zero instead of whatever sits on the read bus.
  always_comb begin
    case (DS)
      2'b00:   d = f;
      2'b01:   d = DW'(pc_q);
      2'b10:   d = b;
      default: d = abort_q ? '0 : mem_rdata;
    endcase
  end

  always_comb begin
    pc_in = PC_Sel ? K[AW-1:0] : a[AW-1:0];
    case (PS)
      2'b01:   pc_nxt = pc_q + AW'(4);
      2'b10:   pc_nxt = pc_in;
      2'b11:   pc_nxt = pc_q + (pc_in << 2);
      default: pc_nxt = pc_q;
    endcase
  end

  assign access    = MW | (DS == 2'b11);
  assign mem_req   = access & ~abort_q;
  assign mem_we    = MW & mem_req;
  assign stall     = mem_req & ~mem_ack;
  assign mem_addr  = AS ? f[AW-1:0] : pc_q;
  assign mem_wdata = b;
  assign bus_err   = bus_err_q;
  assign SF        = sf_q;
  assign PC_Out    = pc_q;
  assign IR_Out    = ir_q;

  // Control state: stall counter, abort cycle, sticky error, PC/IR/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      sf_q      <= '0;
      bus_err_q <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (stall) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        bus_err_q <= 1'b1;
        abort_q   <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
      pc_q    <= pc_nxt;
      if (SL) sf_q <= status;
      if (IL) ir_q <= d[IW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RW && !stall && (DA != XZR)) begin
      rf[DA] <= d;
    end
  end

endmodule

// File: tb/tb_datapath_core_gen.sv
// Scoreboard bench for datapath_core_gen: a driver pushes per-instruction expectations
// from a behavioural model, and a monitor checks them whenever an instruction retires.
module tb_datapath_core_gen;

  localparam int DW = 64, AW = 32, IW = 32, NREG = 8, TIMEOUT = 5;
  localparam logic [31:0] RPC = 32'h100;

  logic clk = 0, rst = 0;
  logic AS, PC_Sel, K_Sel, IL, SL, RW, MW, C0, mem_ack;
  logic [1:0] DS, PS;
  logic [3:0] FS;
  logic [2:0] DA, SA, SB;
  logic [63:0] K, mem_rdata, mem_wdata;
  logic [31:0] mem_addr, PC_Out, IR_Out;
  logic mem_req, mem_we, stall, bus_err;
  logic [3:0] SF;

  datapath_core_gen #(.DW(DW), .AW(AW), .IW(IW), .NREG(NREG), .RESET_PC(RPC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel), .K_Sel(K_Sel),
    .IL(IL), .SL(SL), .RW(RW), .MW(MW), .FS(FS), .C0(C0), .DA(DA), .SA(SA), .SB(SB), .K(K),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .bus_err(bus_err),
    .SF(SF), .PC_Out(PC_Out), .IR_Out(IR_Out));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, addr, ir;
    logic [3:0]  sf;
    logic [63:0] wdata;
    logic        req, we, berr;
    int          stalls;
  } rec_t;

  rec_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit mon_en = 0;
  int scnt = 0;

  logic [63:0] m_reg [NREG];
  logic [31:0] m_pc, m_ir;
  logic [3:0]  m_sf;
  logic        m_berr;
  int          i_wait;
  logic [63:0] i_rdata;
  bit          cur_acc, cur_to;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_pc = RPC; m_ir = '0; m_sf = '0; m_berr = 0;
  endtask

  task automatic nop();
    AS = 0; DS = 0; PS = 0; PC_Sel = 0; K_Sel = 0; IL = 0; SL = 0; RW = 0; MW = 0;
    FS = 0; C0 = 0; DA = 0; SA = 0; SB = 0; K = '0; i_wait = 0; i_rdata = '0;
  endtask

  // Reference ALU written from the arithmetic rules, not the hardware structure.
  task automatic alu(input logic [3:0] fs, input logic [63:0] A, Bop, input logic c0,
                     output logic [63:0] F, output logic [3:0] fl);
    logic [64:0] w;
    logic c, v;
    c = 0; v = 0; F = '0;
    case (fs)
      4'd0: F = A & Bop;
      4'd1: F = A | Bop;
      4'd2: F = A ^ Bop;
      4'd3: F = ~A;
      4'd4: begin
        w = {1'b0, A} + {1'b0, Bop} + {64'd0, c0};
        F = w[63:0]; c = w[64];
        v = (A[63] == Bop[63]) && (F[63] != A[63]);
      end
      4'd5: begin
        F = A - Bop; c = (A >= Bop);
        v = (A[63] != Bop[63]) && (F[63] != A[63]);
      end
      4'd6: F = A << Bop[5:0];
      4'd7: F = A >> Bop[5:0];
      4'd8: F = Bop;
      4'd9: F = A;
      default: F = '0;
    endcase
    fl = {v, c, F[63], F == 64'd0};
  endtask

  // Drive the current instruction fields, predict the retire-cycle view, advance the model.
  task automatic start();
    rec_t r;
    logic [63:0] A, B, Bop, F, D;
    logic [31:0] pin;
    logic [3:0] fl;
    A = m_reg[SA]; B = m_reg[SB];
    Bop = K_Sel ? K : B;
    alu(FS, A, Bop, C0, F, fl);
    cur_acc = MW || (DS == 2'd3);
    cur_to  = cur_acc && (i_wait < 0);
    if (cur_to) m_berr = 1;
    r.pc = m_pc; r.sf = m_sf; r.ir = m_ir; r.wdata = B;
    r.addr = AS ? F[31:0] : m_pc;
    r.req = cur_acc && !cur_to;
    r.we = MW && r.req;
    r.berr = m_berr;
    r.stalls = !cur_acc ? 0 : (cur_to ? TIMEOUT : i_wait);
    q.push_back(r);
    mem_rdata = i_rdata;
    mem_ack = cur_acc ? (i_wait == 0) : 1'($urandom_range(0, 1));
    case (DS)
      2'd0: D = F;
      2'd1: D = {32'd0, m_pc};
      2'd2: D = B;
      default: D = cur_to ? 64'd0 : i_rdata;
    endcase
    if (RW && DA != 3'(NREG - 1)) m_reg[DA] = D;
    if (SL) m_sf = fl;
    if (IL) m_ir = D[31:0];
    pin = PC_Sel ? K[31:0] : A[31:0];
    case (PS)
      2'd1: m_pc = m_pc + 32'd4;
      2'd2: m_pc = pin;
      2'd3: m_pc = m_pc + pin * 32'd4;
      default: ;
    endcase
  endtask

  task automatic complete();
    if (!cur_acc || i_wait == 0) begin
      @(posedge clk); #1;
    end else if (cur_to) begin
      repeat (TIMEOUT + 1) @(posedge clk);
      #1;
    end else begin
      for (int k = 1; k <= i_wait; k++) begin
        @(posedge clk); #1;
        if (k == i_wait) mem_ack = 1;
      end
      @(posedge clk); #1;
    end
    mem_ack = 0;
  endtask

  task automatic run();
    start();
    complete();
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (stall) begin
        scnt++;
        if (scnt > TIMEOUT + 1) begin
          chk("stall_bound", 64'(scnt), 64'(TIMEOUT + 1));
          scnt = 0;
        end
      end else if (q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        rec_t r;
        r = q.pop_front();
        chk("stalls", 64'(scnt), 64'(r.stalls));
        chk("pc", 64'(PC_Out), 64'(r.pc));
        chk("sf", 64'(SF), 64'(r.sf));
        chk("ir", 64'(IR_Out), 64'(r.ir));
        chk("wdata", mem_wdata, r.wdata);
        chk("addr", 64'(mem_addr), 64'(r.addr));
        chk("req", 64'(mem_req), 64'(r.req));
        chk("we", 64'(mem_we), 64'(r.we));
        chk("bus_err", 64'(bus_err), 64'(r.berr));
        scnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] pc0;
    nop(); mem_ack = 0; mem_rdata = '0;
    model_reset();
    // Reset asserted mid-cycle takes effect before the next edge.
    #2 rst = 1;
    #1;
    chk("rst_pc", 64'(PC_Out), 64'(RPC));
    chk("rst_sf", 64'(SF), 64'd0);
    chk("rst_ir", 64'(IR_Out), 64'd0);
    chk("rst_berr", 64'(bus_err), 64'd0);
    @(posedge clk); #1 rst = 0;

    // Reset in the middle of a stalled load clears the stall counter.
    DS = 3; RW = 1; DA = 4;
    #0;
    repeat (3) @(posedge clk);
    #4 rst = 1;
    #1;
    chk("rst_stall_req", 64'(mem_req), 64'd1);
    chk("rst_stall", 64'(stall), 64'd1);
    @(posedge clk); #1 rst = 0;
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    chk("cnt_cleared_berr", 64'(bus_err), 64'd0);
    chk("req_reasserted", 64'(stall), 64'd1);
    mem_rdata = 64'h77; mem_ack = 1;
    @(posedge clk); #1 mem_ack = 0; nop();
    rst = 1; #1;
    @(posedge clk); #1 rst = 0;
    model_reset();
    mon_en = 1;

    // PC modes: relative branch with negative offset, then wrap.
    nop(); PS = 3; PC_Sel = 1; K = -64'sd2; run();
    chk("pc_rel", 64'(PC_Out), 64'h0F8);
    nop(); PS = 2; PC_Sel = 1; K = 64'hFFFF_FFFC; run();
    nop(); PS = 1; run();
    chk("pc_wrap", 64'(PC_Out), 64'd0);

    // ALU and flags.
    nop(); FS = 8; K_Sel = 1; K = 64'h7FFF_FFFF_FFFF_FFFF; RW = 1; DA = 1; run();
    nop(); FS = 8; K_Sel = 1; K = 64'd1; RW = 1; DA = 2; run();
    nop(); FS = 4; SA = 1; SB = 2; SL = 1; RW = 1; DA = 3; run();
    chk("sf_add_ovf", 64'(SF), 64'b1010);
    nop(); FS = 5; SA = 1; SB = 1; SL = 1; run();
    chk("sf_sub_zero", 64'(SF), 64'b0101);
    nop(); SB = 3; start(); #1 chk("r3_sum", mem_wdata, 64'h8000_0000_0000_0000); complete();

    // Zero register and no write bypass.
    nop(); FS = 8; K_Sel = 1; K = 64'h55; RW = 1; DA = 7; run();
    nop(); SB = 7; start(); #1 chk("xzr_read", mem_wdata, 64'd0); complete();
    nop(); FS = 8; K_Sel = 1; K = 64'h11; RW = 1; DA = 5; run();
    nop(); FS = 8; K_Sel = 1; K = 64'h22; RW = 1; DA = 5; SB = 5; start();
    #1 chk("no_bypass", mem_wdata, 64'h11); complete();
    nop(); SB = 5; start(); #1 chk("r5_new", mem_wdata, 64'h22); complete();

    // Load with three wait cycles.
    nop(); DS = 3; RW = 1; DA = 4; PS = 1; i_wait = 3; i_rdata = 64'hABCD;
    pc0 = PC_Out; run();
    chk("load_pc", 64'(PC_Out), 64'(pc0 + 32'd4));
    nop(); SB = 4; start(); #1 chk("load_r4", mem_wdata, 64'hABCD); complete();

    // Store timeout, then an aborted load writing zero.
    nop(); MW = 1; SB = 2; PS = 1; i_wait = -1;
    pc0 = PC_Out; run();
    chk("to_berr", 64'(bus_err), 64'd1);
    chk("to_pc", 64'(PC_Out), 64'(pc0 + 32'd4));
    nop(); FS = 8; K_Sel = 1; K = 64'h99; RW = 1; DA = 6; run();
    nop(); DS = 3; RW = 1; DA = 6; i_wait = -1; i_rdata = 64'hDEAD; run();
    nop(); SB = 6; start(); #1 chk("to_load_zero", mem_wdata, 64'd0); complete();

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      int sel;
      nop();
      AS = 1'($urandom); PS = 2'($urandom); PC_Sel = 1'($urandom); K_Sel = 1'($urandom);
      IL = 1'($urandom); SL = 1'($urandom); RW = 1'($urandom); C0 = 1'($urandom);
      FS = 4'($urandom_range(0, 11));
      DA = 3'($urandom); SA = 3'($urandom); SB = 3'($urandom);
      K = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) K = 64'($urandom_range(0, 70));
      i_rdata = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        DS = 2'($urandom_range(0, 2));
      end else begin
        MW = 1'($urandom);
        DS = MW ? 2'($urandom) : 2'd3;
        i_wait = $urandom_range(0, 3);
        if (sel == 9 && $urandom_range(0, 3) == 0) i_wait = -1;
      end
      run();
    end
    nop(); run();
    @(negedge clk);
    mon_en = 0;
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
